// File: rtl/regseq_pkg.sv
// Shared encodings for regfile_sequencer: command opcodes, FSM states, register count.
package regseq_pkg;

  localparam int NREG = 16;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_ADD    = 2'b01,
    OP_SERIES = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for the RegFile2 port set (load / add / series-add / clear).
// Optional sticky carry flag on the overflow port when SEQ_OVERFLOW_FLAG_EN is defined.
module regfile_sequencer
  import regseq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_srca,
  input  logic [AW-1:0]    cmd_srcb,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [AW-1:0]    cmd_count,
  output logic             WriteEnable,
  output logic [AW-1:0]    SelectInput,
  output logic [AW-1:0]    SelectA,
  output logic [AW-1:0]    SelectB,
  output logic [WIDTH-1:0] In,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [AW-1:0]    srca_q, srca_d;
  logic [AW-1:0]    srcb_q, srcb_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic [AW-1:0]    sel_in_q, sel_in_d;
  logic [AW-1:0]    sel_a_q, sel_a_d;
  logic [AW-1:0]    sel_b_q, sel_b_d;
  logic [WIDTH-1:0] in_q, in_d;
  logic [WIDTH-1:0] sum_rd;
  logic             accept;

`ifdef SEQ_OVERFLOW_FLAG_EN
  logic [WIDTH:0] add_full;
  logic           ovf_q, ovf_d;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sum_rd   = add_full[WIDTH-1:0];
  assign overflow = ovf_q;
`else
  assign sum_rd   = A + B;
  assign overflow = 1'b0;
`endif

  assign cmd_ready   = (state_q == IDLE) && !Reset;
  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign WriteEnable = we_q;
  assign SelectInput = sel_in_q;
  assign SelectA     = sel_a_q;
  assign SelectB     = sel_b_q;
  assign In          = in_q;

  // Outputs are computed for the state being entered so they appear registered in that state.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    sum_d    = sum_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    sel_in_d = sel_in_q;
    sel_a_d  = sel_a_q;
    sel_b_d  = sel_b_q;
    in_d     = in_q;
`ifdef SEQ_OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = op_e'(cmd_op);
          dst_d  = cmd_dst;
          srca_d = cmd_srca;
          srcb_d = cmd_srcb;
          cnt_d  = cmd_count;
          k_d    = '0;
          case (op_e'(cmd_op))
            OP_LOAD: begin
              state_d  = WRITE;
              sum_d    = cmd_imm;
              we_d     = 1'b1;
              sel_in_d = cmd_dst;
              in_d     = cmd_imm;
            end
            OP_ADD, OP_SERIES: begin
              state_d = READ;
              sel_a_d = cmd_srca;
              sel_b_d = cmd_srcb;
            end
            default: begin
              state_d  = CLEAR;
              we_d     = 1'b1;
              sel_in_d = '0;
              in_d     = '0;
`ifdef SEQ_OVERFLOW_FLAG_EN
              ovf_d    = 1'b0;
`endif
            end
          endcase
        end
      end

      READ: begin
        state_d  = WRITE;
        sum_d    = sum_rd;
        we_d     = 1'b1;
        sel_in_d = dst_q + k_q;
        in_d     = sum_rd;
`ifdef SEQ_OVERFLOW_FLAG_EN
        ovf_d    = ovf_q | add_full[WIDTH];
`endif
      end

      WRITE: begin
        if (op_q == OP_SERIES && k_q != cnt_q) begin
          k_d     = k_q + 1'b1;
          state_d = READ;
          sel_a_d = srca_q + k_d;
          sel_b_d = srcb_q + k_d;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      CLEAR: begin
        if (k_q == AW'(NREG - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          k_d      = k_q + 1'b1;
          we_d     = 1'b1;
          sel_in_d = k_d;
          in_d     = '0;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      op_q     <= OP_LOAD;
      dst_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      sel_in_q <= '0;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      in_q     <= '0;
`ifdef SEQ_OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      sum_q    <= sum_d;
      we_q     <= we_d;
      done_q   <= done_d;
      sel_in_q <= sel_in_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      in_q     <= in_d;
`ifdef SEQ_OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 16x16 register file as responder.
module tb_regfile_sequencer;

  logic        Clock;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_dst;
  logic [3:0]  cmd_srca;
  logic [3:0]  cmd_srcb;
  logic [15:0] cmd_imm;
  logic [3:0]  cmd_count;
  logic        WriteEnable;
  logic [3:0]  SelectInput;
  logic [3:0]  SelectA;
  logic [3:0]  SelectB;
  logic [15:0] In;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic        overflow;

  logic [15:0] rf [16];

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sequencer #(.WIDTH(16), .AW(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_imm(cmd_imm), .cmd_count(cmd_count),
    .WriteEnable(WriteEnable), .SelectInput(SelectInput),
    .SelectA(SelectA), .SelectB(SelectB), .In(In), .A(A), .B(B),
    .busy(busy), .done(done), .overflow(overflow)
  );

  // RegFile2 stand-in: synchronous write, combinational reads
  always @(posedge Clock) if (WriteEnable) rf[SelectInput] <= In;
  assign A = rf[SelectA];
  assign B = rf[SelectB];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] sa,
                       input logic [3:0] sb, input logic [15:0] imm, input logic [3:0] cnt);
    int w;
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm; cmd_count = cnt;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      tick;
      w++;
    end
    if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] dst, input logic [15:0] imm);
    issue(2'b00, dst, 4'd0, 4'd0, imm, 4'd0);
    check("load_we", 32'(WriteEnable), 32'd1);
    check("load_sel", 32'(SelectInput), 32'(dst));
    check("load_in", 32'(In), 32'(imm));
    check("load_busy", 32'(busy), 32'd1);
    tick;
    check("load_done", 32'(done), 32'd1);
    check("load_we_off", 32'(WriteEnable), 32'd0);
    tick;
    check("load_done_off", 32'(done), 32'd0);
    check("load_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] fib [16];
    logic [15:0] acc;
    logic [3:0]  wr [4];
    int act, nw, ndone, nwe;
    bit seen;

    fib = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
            16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987};
    Reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0;
    cmd_srcb = '0; cmd_imm = '0; cmd_count = '0;

    // 1. reset state and two loads
    tick; tick;
    check("rst_we", 32'(WriteEnable), 32'd0);
    check("rst_sel", {SelectInput, SelectA, SelectB}, 32'd0);
    check("rst_in", 32'(In), 32'd0);
    check("rst_busy_done", {busy, done, overflow}, 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    Reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);
    do_load(4'd0, 16'd1);
    do_load(4'd1, 16'd1);
    check("r0", 32'(rf[0]), 32'd1);
    check("r1", 32'(rf[1]), 32'd1);

    // 2. Fibonacci series, 14 elements
    issue(2'b10, 4'd2, 4'd0, 4'd1, 16'd0, 4'd13);
    act = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) act++;
        tick;
      end
    end
    check("series_done_seen", 32'(seen), 32'd1);
    check("series_cycles", 32'(act), 32'd28);
    tick;
    for (int i = 2; i < 16; i++) check($sformatf("fib_r%0d", i), 32'(rf[i]), 32'(fib[i]));
    check("ovf_after_fib", 32'(overflow), 32'd0);

    // 3. ADD with carry out
    do_load(4'd3, 16'hFFFF);
    do_load(4'd4, 16'h0002);
    issue(2'b01, 4'd5, 4'd3, 4'd4, 16'd0, 4'd0);
    check("add_read_we", 32'(WriteEnable), 32'd0);
    check("add_sela", 32'(SelectA), 32'd3);
    check("add_selb", 32'(SelectB), 32'd4);
    tick;
    check("add_we", 32'(WriteEnable), 32'd1);
    check("add_sel", 32'(SelectInput), 32'd5);
    check("add_in", 32'(In), 32'h0001);
    tick;
    check("add_done", 32'(done), 32'd1);
    tick;
    check("r5", 32'(rf[5]), 32'h0001);
`ifdef SEQ_OVERFLOW_FLAG_EN
    check("add_ovf", 32'(overflow), 32'd1);
`else
    check("add_ovf", 32'(overflow), 32'd0);
`endif

    // 4. CLEAR
    issue(2'b11, 4'd0, 4'd0, 4'd0, 16'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("clr_we%0d", i), 32'(WriteEnable), 32'd1);
      check($sformatf("clr_sel%0d", i), 32'(SelectInput), 32'(i));
      check($sformatf("clr_in%0d", i), 32'(In), 32'd0);
      tick;
    end
    check("clr_done", 32'(done), 32'd1);
    check("clr_we_off", 32'(WriteEnable), 32'd0);
    tick;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | rf[i];
    check("clr_all_zero", 32'(acc), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);

    // 5. Reset during SERIES at k=5
    issue(2'b10, 4'd0, 4'd0, 4'd0, 16'd0, 4'd15);
    for (int i = 0; i < 40 && !(WriteEnable && SelectInput == 4'd5); i++) tick;
    check("abort_at_k5", {WriteEnable, SelectInput}, {1'b1, 4'd5});
    Reset = 1'b1;
    #1;
    check("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
    tick;
    check("abort_we", 32'(WriteEnable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sel", 32'(SelectInput), 32'd0);
    Reset = 1'b0;
    #1;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    ndone = 0; nwe = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      if (WriteEnable) nwe++;
      tick;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_no_we", 32'(nwe), 32'd0);

    // 6. cmd_valid held through busy; second command is a wrapping series
    cmd_op = 2'b00; cmd_dst = 4'd7; cmd_imm = 16'h1234; cmd_count = 4'd0;
    cmd_valid = 1'b1;
    tick;
    cmd_op = 2'b10; cmd_dst = 4'd15; cmd_srca = 4'd7; cmd_srcb = 4'd14;
    cmd_imm = 16'hDEAD; cmd_count = 4'd1;
    check("hold_we", 32'(WriteEnable), 32'd1);
    check("hold_sel", 32'(SelectInput), 32'd7);
    check("hold_in", 32'(In), 32'h1234);
    check("hold_ready_busy", 32'(cmd_ready), 32'd0);
    tick;
    check("hold_done", 32'(done), 32'd1);
    check("hold_ready_done", 32'(cmd_ready), 32'd0);
    tick;
    check("hold_ready_idle", 32'(cmd_ready), 32'd1);
    check("hold_idle", 32'(busy), 32'd0);
    tick;
    cmd_valid = 1'b0;
    check("wrap_busy", 32'(busy), 32'd1);
    check("wrap_sela", 32'(SelectA), 32'd7);
    check("wrap_selb", 32'(SelectB), 32'd14);
    nw = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (WriteEnable && nw < 4) begin
        wr[nw] = SelectInput;
        nw++;
      end
      if (done) seen = 1;
      else tick;
    end
    check("wrap_done_seen", 32'(seen), 32'd1);
    check("wrap_nwrites", 32'(nw), 32'd2);
    check("wrap_first", 32'(wr[0]), 32'd15);
    check("wrap_second", 32'(wr[1]), 32'd0);
    tick;
    check("r7", 32'(rf[7]), 32'h1234);
    check("r15", 32'(rf[15]), 32'h1234);
    check("r0_wrap", 32'(rf[0]), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
